mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//  Iterative 32-bit multiply/divide unit in the execute stage, directly downstream of the
//  register file. Consumes the RD1/RD2 operand pair for MULT(U)/DIV(U), produces a 64-bit
//  result in internal HI/LO registers, and supports MTHI/MTLO writes. Results are read back
//  through Hi/Lo, which feed the writeback mux for MFHI/MFLO. One radix-2 step per cycle.
// PARAMETERS
//  WIDTH   32  operand width; HI and LO are WIDTH bits each
//  CNT_W   5   iteration counter width; must equal clog2(WIDTH)
// PORTS
//  Clk     in   1      clock, rising edge
//  Reset   in   1      asynchronous, active-high; clears all state
//  Start   in   1      launch operation; sampled only when Busy==0
//  Op      in   2      00 MULTU, 01 DIVU, 10 MULT, 11 DIV
//  A       in   WIDTH  multiplicand / dividend (RD1)
//  B       in   WIDTH  multiplier / divisor (RD2)
//  HiWr    in   1      MTHI strobe
//  LoWr    in   1      MTLO strobe
//  WData   in   WIDTH  data for MTHI/MTLO
//  Busy    out  1      operation in progress
//  Done    out  1      one-cycle pulse: Hi/Lo hold the new result
//  Hi      out  WIDTH  HI register (product[63:32] / remainder)
//  Lo      out  WIDTH  LO register (product[31:0] / quotient)
// BEHAVIOUR
//  - Reset: state IDLE, counter 0, Busy=0, Done=0, Hi=0, Lo=0, operand and shift regs 0.
//  - FSM states: IDLE, RUN, FIN.
//  - IDLE/FIN, Start=1 at edge E0: latch A, B, Op; counter=0; go to RUN.
//  - IDLE/FIN, Start=0: FIN goes to IDLE; IDLE stays in IDLE.
//  - RUN: one iteration per edge at E1..E32 (32 cycles); Busy=1 for exactly those cycles.
//  - RUN at E32 (counter==31): write Hi/Lo and go to FIN.
//  - FIN: Done=1 and Busy=0 for one cycle; a new Start is accepted in FIN (back-to-back).
//  - Multiply: shift-add on a 64-bit accumulator; {Hi,Lo} = A*B.
//  - Divide: restoring, 33-bit partial remainder; Lo = quotient, Hi = remainder.
//  - Divide by zero: no trap, still 32 cycles; Lo=32'hFFFFFFFF, Hi=A (unsigned path).
//  - Start while Busy=1: ignored, no effect on the running operation.
//  - HiWr/LoWr while Busy=1: ignored, write is dropped.
//  - HiWr/LoWr in IDLE/FIN: update the register at the next edge; both may assert together.
//  - Start together with HiWr/LoWr in IDLE/FIN: Start wins, MT write is dropped.
//  - Hi/Lo hold their value from Start until E32; the old value stays readable during RUN.
//  - Reset mid-operation: aborts immediately; all outputs return to reset values; no Done.
// CONFIGURATION
//  SIGNED_MD_EN defined:
//   - Op 10/11 are signed; operand magnitudes are taken at Start.
//   - Sign is fixed combinationally at the E32 write; latency is unchanged.
//   - Quotient truncates toward zero; remainder takes the sign of the dividend.
//   - 32'h80000000 / 32'hFFFFFFFF gives Lo=32'h80000000, Hi=0.
//   - Signed divide by zero: Lo = (A<0) ? 1 : 32'hFFFFFFFF, Hi=A.
//  SIGNED_MD_EN undefined:
//   - Op[1] is ignored; MULT behaves as MULTU and DIV behaves as DIVU.
//   - No sign logic is synthesised.
// TESTING
//  1. MULTU A=32'hFFFFFFFF B=32'hFFFFFFFF -> Done at cycle 33 after Start,
//     Hi=32'hFFFFFFFE Lo=32'h00000001, Busy high exactly 32 cycles.
//  2. DIVU A=100 B=7 -> Lo=14 Hi=2; then DIVU A=5 B=0 -> Lo=32'hFFFFFFFF Hi=5.
//  3. Start DIVU; re-pulse Start and HiWr(WData=32'hDEAD) at cycle 10 ->
//     both ignored, result unchanged, Hi is not 32'hDEAD.
//  4. Reset asserted at cycle 15 of a MULTU -> Busy=0 Done=0 Hi=Lo=0 immediately;
//     no Done pulse afterwards.
//  5. Start in FIN cycle (back-to-back MULTU 3*4 then MULTU 5*6) ->
//     Lo=12 then Lo=30, Done pulses 33 cycles apart.
//  6. With SIGNED_MD_EN: MULT -3*5 -> {Hi,Lo}=64'hFFFFFFFF_FFFFFFF1; DIV -7/2 -> Lo=-3 Hi=-1;
//     without the macro, DIV -7/2 -> Lo=32'h7FFFFFFC Hi=1.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// One radix-2 step per cycle: shift-add multiply, restoring divide.
// Optional macro SIGNED_MD_EN enables signed MULT/DIV for Op[1]=1; when it is
// undefined Op[1] is ignored and no sign logic exists.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             HiWr,
  input  logic             LoWr,
  input  logic [WIDTH-1:0] WData,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               div_q;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits shifting into quotient bits}.
  logic [2*WIDTH-1:0] acc_q, acc_step;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic               accept, last;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_sub;
  logic               div_ge;

  assign accept = (state_q != RUN) && Start;
  assign last   = (state_q == RUN) && (cnt_q == CNT_W'(WIDTH - 1));
  assign Busy   = (state_q == RUN);
  assign Done   = (state_q == FIN);
  assign Hi     = hi_q;
  assign Lo     = lo_q;

`ifdef SIGNED_MD_EN
  logic neg_a_in, neg_b_in;
  logic neg_a_q, neg_b_q;

  // Signed ops run on magnitudes; the original signs are kept for the final fix-up.
  always_comb begin
    neg_a_in = Op[1] & A[WIDTH-1];
    neg_b_in = Op[1] & B[WIDTH-1];
    a_mag    = neg_a_in ? -A : A;
    b_mag    = neg_b_in ? -B : B;
  end

  // Latch operand signs at launch.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
    end else if (accept) begin
      neg_a_q <= neg_a_in;
      neg_b_q <= neg_b_in;
    end
  end
`else
  logic unused_op;
  assign unused_op = Op[1];

  // Unsigned only: operands pass straight through.
  always_comb begin
    a_mag = A;
    b_mag = B;
  end
`endif

  // One radix-2 iteration of the selected operation.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    div_ge    = div_shift >= {1'b0, b_q};
    // The difference always fits in WIDTH bits when div_ge holds.
    div_sub   = div_shift[WIDTH-1:0] - b_q;
    if (div_q) begin
      if (div_ge) acc_step = {div_sub, acc_q[WIDTH-2:0], 1'b1};
      else        acc_step = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  // Final result with sign correction applied on the last step.
  always_comb begin
    res_hi = acc_step[2*WIDTH-1:WIDTH];
    res_lo = acc_step[WIDTH-1:0];
`ifdef SIGNED_MD_EN
    if (!div_q) begin
      if (neg_a_q ^ neg_b_q) {res_hi, res_lo} = -acc_step;
    end else begin
      if (neg_a_q ^ neg_b_q) res_lo = -acc_step[WIDTH-1:0];
      if (neg_a_q)           res_hi = -acc_step[2*WIDTH-1:WIDTH];
    end
`endif
  end

  // Next-state logic for IDLE -> RUN -> FIN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (Start) state_d = RUN;
      RUN:     if (last) state_d = FIN;
      FIN:     state_d = Start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state, operands, iteration counter and datapath accumulator.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      div_q   <= 1'b0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q   <= a_mag;
        b_q   <= b_mag;
        div_q <= Op[0];
        cnt_q <= '0;
        acc_q <= {{WIDTH{1'b0}}, (Op[0] ? a_mag : b_mag)};
      end else if (state_q == RUN) begin
        acc_q <= acc_step;
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // HI/LO: result write on the last step, MTHI/MTLO only when idle and not launching.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (last) begin
      hi_q <= res_hi;
      lo_q <= res_lo;
    end else if ((state_q != RUN) && !Start) begin
      if (HiWr) hi_q <= WData;
      if (LoWr) lo_q <= WData;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus random ops against
// an arithmetic reference model.
module tb_mul_div_unit;

  logic        Clk, Reset, Start, HiWr, LoWr, Busy, Done;
  logic [1:0]  Op;
  logic [31:0] A, B, WData, Hi, Lo;

  int  nchk = 0;
  int  nerr = 0;
  time last_done_t = 0;

  mul_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .HiWr(HiWr), .LoWr(LoWr), .WData(WData),
    .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: {HI, LO} from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
`ifdef SIGNED_MD_EN
    if (op[1]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (!op[0]) begin
        p = sa * sb;
        return p;
      end
      if (b == 32'd0) return {a, (a[31] ? 32'd1 : 32'hFFFFFFFF)};
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
    end
`endif
    if (!op[0]) return {32'd0, a} * {32'd0, b};
    if (b == 32'd0) return {a, 32'hFFFFFFFF};
    return {a % b, a / b};
  endfunction

  // Launch one op (from IDLE or FIN) and wait for Done. A poke cycle >= 0 re-pulses
  // Start with HiWr mid-run, which must be ignored.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int poke);
    logic [63:0] exp;
    logic [31:0] old_hi, old_lo;
    int n, busy_n, hold_bad;
    exp    = model(op, a, b);
    old_hi = Hi;
    old_lo = Lo;
    Op = op; A = a; B = b; Start = 1'b1;
    tick();
    Start = 1'b0; HiWr = 1'b0; LoWr = 1'b0;
    A = $urandom; B = $urandom; Op = 2'($urandom);
    n = 0; busy_n = 0; hold_bad = 0;
    while (!Done && n < 40) begin
      if (Busy) busy_n++;
      if (Hi !== old_hi || Lo !== old_lo) hold_bad++;
      if (n == poke) begin
        Start = 1'b1; HiWr = 1'b1; WData = 32'hDEAD;
      end
      tick();
      Start = 1'b0; HiWr = 1'b0;
      n++;
    end
    last_done_t = $time;
    chk("latency", 64'(n), 64'd32);
    chk("busy_cycles", 64'(busy_n), 64'd32);
    chk("hold_old", 64'(hold_bad), 64'd0);
    chk("hi", {32'd0, Hi}, {32'd0, exp[63:32]});
    chk("lo", {32'd0, Lo}, {32'd0, exp[31:0]});
  endtask

  initial begin
    time t1;
    int  nd;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    Reset = 1'b1; Start = 1'b0; Op = 2'b00; A = '0; B = '0;
    HiWr = 1'b0; LoWr = 1'b0; WData = '0;
    #1;
    chk("rst_state", {Busy, Done, Hi, Lo}, 66'd0);
    tick(); tick();
    Reset = 1'b0;
    tick();
    chk("post_rst", {Busy, Done, Hi, Lo}, 66'd0);

    // MULTU max * max
    do_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, -1);
    chk("mulmax", {Hi, Lo}, 64'hFFFFFFFE_00000001);
    chk("done_pulse", {63'd0, Done}, 64'd1);
    tick();
    chk("done_one_cycle", {62'd0, Done, Busy}, 64'd0);

    // DIVU 100/7 then divide by zero
    do_op(2'b01, 32'd100, 32'd7, -1);
    chk("div100_7", {Hi, Lo}, {32'd2, 32'd14});
    do_op(2'b01, 32'd5, 32'd0, -1);
    chk("div_by0", {Hi, Lo}, {32'd5, 32'hFFFFFFFF});

    // Start + MTHI mid-run are ignored
    do_op(2'b01, 32'd1000, 32'd3, 9);
    chk("poke_hi_not_dead", {63'd0, Hi == 32'hDEAD}, 64'd0);
    tick();

    // MTHI/MTLO in IDLE, both together then HI alone
    HiWr = 1'b1; LoWr = 1'b1; WData = 32'hCAFE0001;
    tick();
    HiWr = 1'b0; LoWr = 1'b0;
    chk("mt_both", {Hi, Lo}, {32'hCAFE0001, 32'hCAFE0001});
    HiWr = 1'b1; WData = 32'h0BAD0002;
    tick();
    HiWr = 1'b0;
    chk("mthi_only", {Hi, Lo}, {32'h0BAD0002, 32'hCAFE0001});

    // Start with MTLO: MT dropped, old values held through RUN
    LoWr = 1'b1; WData = 32'h12345678;
    do_op(2'b00, 32'd7, 32'd9, -1);
    chk("start_beats_mt", {Hi, Lo}, {32'd0, 32'd63});

    // Reset mid-operation
    tick();
    Op = 2'b00; A = 32'hFFFF; B = 32'hFFFF; Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (14) tick();
    chk("busy_before_rst", {63'd0, Busy}, 64'd1);
    Reset = 1'b1;
    #1;
    chk("rst_mid", {Busy, Done, Hi, Lo}, 66'd0);
    tick();
    Reset = 1'b0;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      if (Done || Busy) nd++;
      tick();
    end
    chk("no_done_after_rst", 64'(nd), 64'd0);

    // Back-to-back: second Start lands in the FIN cycle
    do_op(2'b00, 32'd3, 32'd4, -1);
    chk("b2b_first", {32'd0, Lo}, 64'd12);
    t1 = last_done_t;
    do_op(2'b00, 32'd5, 32'd6, -1);
    chk("b2b_second", {32'd0, Lo}, 64'd30);
    chk("b2b_gap", 64'((last_done_t - t1) / 10), 64'd33);

    // Signed-capable opcodes
    do_op(2'b10, 32'hFFFFFFFD, 32'd5, -1);
`ifdef SIGNED_MD_EN
    chk("mult_neg", {Hi, Lo}, 64'hFFFFFFFF_FFFFFFF1);
`else
    chk("mult_neg", {Hi, Lo}, 64'h00000004_FFFFFFF1);
`endif
    do_op(2'b11, 32'hFFFFFFF9, 32'd2, -1);
`ifdef SIGNED_MD_EN
    chk("div_neg", {Hi, Lo}, 64'hFFFFFFFF_FFFFFFFD);
`else
    chk("div_neg", {Hi, Lo}, 64'h00000001_7FFFFFFC);
`endif
    do_op(2'b11, 32'h80000000, 32'hFFFFFFFF, -1);
    do_op(2'b11, 32'hFFFFFF00, 32'd0, -1);
    do_op(2'b11, 32'd77, 32'hFFFFFFF6, -1);

    // Random operations, occasionally with zero or small divisors
    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 100));
        default: rb = $urandom;
      endcase
      do_op(rop, ra, rb, -1);
    end
    tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
